// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life board engine.
package life_pkg;

  // Run/step control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Width of a neighbour count (0..8).
  localparam int NBR_W = 4;

  // Classic Conway rule: born on 3, survive on 2 or 3.
  localparam logic [8:0] BIRTH_B3    = 9'b000001000;
  localparam logic [8:0] SURVIVE_S23 = 9'b000001100;

endpackage

// File: rtl/life_cell.sv
// One board cell: counts its eight neighbours and applies the birth/survive
// masks to produce the cell's value in the next generation.
module life_cell
  import life_pkg::*;
(
  input  logic [7:0] nbrs,
  input  logic       cur,
  input  logic [8:0] birth_mask,
  input  logic [8:0] survive_mask,
  output logic       nxt
);

  logic [NBR_W-1:0] cnt;

  // Population count of the neighbour bits, then rule lookup by count.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + NBR_W'(nbrs[i]);
    end
    nxt = cur ? survive_mask[cnt] : birth_mask[cnt];
  end

endmodule

// File: rtl/life_grid.sv
// Parametrised Game-of-Life board: ROWS x COLS cells, run/step control FSM,
// generation counter, extinction and period-1/period-2 detection with
// optional auto-halt. Board state drives the LED driver directly.
module life_grid
  import life_pkg::*;
#(
  parameter int         ROWS         = 16,
  parameter int         COLS         = 16,
  parameter int         GEN_W        = 16,
  parameter logic [8:0] BIRTH_MASK   = BIRTH_B3,
  parameter logic [8:0] SURVIVE_MASK = SURVIVE_S23
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [ROWS-1:0][COLS-1:0] initial_pixels,
  input  logic                      wrap,
  input  logic                      run,
  input  logic                      step,
  input  logic                      tick,
  input  logic                      auto_halt,
  output logic [ROWS-1:0][COLS-1:0] pixels,
  output logic [GEN_W-1:0]          gen_count,
  output logic                      extinct,
  output logic                      stable,
  output logic                      osc2,
  output logic                      running,
  output state_t                    state_dbg
);

  logic [ROWS-1:0][COLS-1:0] next_board;
  logic [ROWS-1:0][COLS-1:0] prev;
  state_t                    state_q;
  state_t                    state_d;
  logic                      adv;
  logic                      halt_hit;

  // Cell array. Neighbour indices wrap around the board; on the border the
  // off-board neighbours are masked to 0 unless toroidal mode is selected.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int RU = (r == 0)        ? ROWS - 1 : r - 1;
      localparam int RD = (r == ROWS - 1) ? 0        : r + 1;
      localparam int CL = (c == 0)        ? COLS - 1 : c - 1;
      localparam int CR = (c == COLS - 1) ? 0        : c + 1;

      logic       ok_u;
      logic       ok_d;
      logic       ok_l;
      logic       ok_r;
      logic [7:0] nbrs;

      assign ok_u = wrap || (r != 0);
      assign ok_d = wrap || (r != ROWS - 1);
      assign ok_l = wrap || (c != 0);
      assign ok_r = wrap || (c != COLS - 1);

      assign nbrs = {ok_u & ok_l & pixels[RU][CL],
                     ok_u        & pixels[RU][c],
                     ok_u & ok_r & pixels[RU][CR],
                     ok_l        & pixels[r][CL],
                     ok_r        & pixels[r][CR],
                     ok_d & ok_l & pixels[RD][CL],
                     ok_d        & pixels[RD][c],
                     ok_d & ok_r & pixels[RD][CR]};

      life_cell u_cell (
        .nbrs         (nbrs),
        .cur          (pixels[r][c]),
        .birth_mask   (BIRTH_MASK),
        .survive_mask (SURVIVE_MASK),
        .nxt          (next_board[r][c])
      );
    end
  end

  // Advance qualification and the conditions the coming advance will flag.
  always_comb begin
    adv      = !load && (((state_q == RUN) && tick) || ((state_q == IDLE) && step));
    halt_hit = (next_board == '0) ||
               (next_board == pixels) ||
               ((next_board == prev) && (gen_count != '0));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; load returns to IDLE from any state.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (run) state_d = RUN;
        RUN: begin
          if (!run) begin
            state_d = IDLE;
          end else if (auto_halt && adv && halt_hit) begin
            state_d = HALT;
          end
        end
        HALT: if (!run) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Board, history, generation counter and steady-state flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pixels    <= '0;
      prev      <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
      osc2      <= 1'b0;
    end else if (load) begin
      pixels    <= initial_pixels;
      prev      <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
      osc2      <= 1'b0;
    end else if (adv) begin
      prev      <= pixels;
      pixels    <= next_board;
      if (gen_count != {GEN_W{1'b1}}) begin
        gen_count <= gen_count + GEN_W'(1);
      end
      stable    <= (next_board == pixels);
      osc2      <= (next_board == prev) && (gen_count != '0);
    end
  end

  // Status outputs derived from registered state.
  always_comb begin
    extinct   = (pixels == '0);
    running   = (state_q == RUN);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_life_grid.sv
// Directed bench for life_grid: a vector table on a 16x16 board plus
// hand-written sequences for glider, auto-halt, custom rule and saturation.
module tb_life_grid;
  import life_pkg::*;

  typedef logic [15:0][15:0] b16_t;

  typedef struct {
    logic       ld, st, rn, tk, wr, ah;
    b16_t       init;
    b16_t       exp_pix;
    logic [15:0] exp_gen;
    logic       exp_st, exp_osc, exp_run, exp_ext;
  } vec_t;

  // clock / shared controls
  logic clk = 1'b0;
  logic reset, load, wrap, run, step, tick, auto_halt;

  // 16x16, default rules
  b16_t        i16, p16;
  logic [15:0] g16;
  logic        e16, s16, o16, r16;
  state_t      d16;
  // 8x8, default rules
  logic [7:0][7:0] i8, p8;
  logic [15:0]     g8;
  logic            e8, s8, o8, r8;
  state_t          d8;
  // 5x5, Seeds rule
  logic [4:0][4:0] i5s, p5s;
  logic [15:0]     g5s;
  logic            e5s, s5s, o5s, r5s;
  state_t          d5s;
  // 5x5, default rules, 3-bit generation counter
  logic [4:0][4:0] i5t, p5t;
  logic [2:0]      g5t;
  logic            e5t, s5t, o5t, r5t;
  state_t          d5t;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  life_grid #(.ROWS(16), .COLS(16)) u16 (
    .clk(clk), .reset(reset), .load(load), .initial_pixels(i16), .wrap(wrap),
    .run(run), .step(step), .tick(tick), .auto_halt(auto_halt),
    .pixels(p16), .gen_count(g16), .extinct(e16), .stable(s16), .osc2(o16),
    .running(r16), .state_dbg(d16));

  life_grid #(.ROWS(8), .COLS(8)) u8 (
    .clk(clk), .reset(reset), .load(load), .initial_pixels(i8), .wrap(wrap),
    .run(run), .step(step), .tick(tick), .auto_halt(auto_halt),
    .pixels(p8), .gen_count(g8), .extinct(e8), .stable(s8), .osc2(o8),
    .running(r8), .state_dbg(d8));

  life_grid #(.ROWS(5), .COLS(5), .BIRTH_MASK(9'b000000100), .SURVIVE_MASK(9'b000000000)) u5s (
    .clk(clk), .reset(reset), .load(load), .initial_pixels(i5s), .wrap(wrap),
    .run(run), .step(step), .tick(tick), .auto_halt(auto_halt),
    .pixels(p5s), .gen_count(g5s), .extinct(e5s), .stable(s5s), .osc2(o5s),
    .running(r5s), .state_dbg(d5s));

  life_grid #(.ROWS(5), .COLS(5), .GEN_W(3)) u5t (
    .clk(clk), .reset(reset), .load(load), .initial_pixels(i5t), .wrap(wrap),
    .run(run), .step(step), .tick(tick), .auto_halt(auto_halt),
    .pixels(p5t), .gen_count(g5t), .extinct(e5t), .stable(s5t), .osc2(o5t),
    .running(r5t), .state_dbg(d5t));

  // scoreboard compare
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock, sampled 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    load = 1'b0; step = 1'b0; run = 1'b0; tick = 1'b0; auto_halt = 1'b0;
  endtask

  function automatic b16_t set16(input b16_t b, input int r, input int c);
    b16_t t;
    t = b;
    t[r][c] = 1'b1;
    return t;
  endfunction

  // ctl = {ld, st, rn, tk, wr, ah}; flags = {stable, osc2, running, extinct}
  function automatic vec_t mkv(input logic [5:0] ctl, input b16_t init, input b16_t px,
                               input logic [15:0] g, input logic [3:0] flags);
    vec_t v;
    {v.ld, v.st, v.rn, v.tk, v.wr, v.ah} = ctl;
    v.init    = init;
    v.exp_pix = px;
    v.exp_gen = g;
    {v.exp_st, v.exp_osc, v.exp_run, v.exp_ext} = flags;
    return v;
  endfunction

  initial begin
    b16_t z, hbar, vbar, blk, cbar, cdom, cwrap;
    logic [7:0][7:0] glider, corner_blk;
    logic [4:0][4:0] seeds_exp, blink5;
    vec_t vecs[22];

    z     = '0;
    hbar  = set16(set16(set16(z, 7, 6), 7, 7), 7, 8);
    vbar  = set16(set16(set16(z, 6, 7), 7, 7), 8, 7);
    blk   = set16(set16(set16(set16(z, 4, 4), 4, 5), 5, 4), 5, 5);
    cbar  = set16(set16(set16(z, 0, 0), 0, 1), 0, 2);
    cdom  = set16(set16(z, 0, 1), 1, 1);
    cwrap = set16(cdom, 15, 1);

    vecs[0]  = mkv(6'b100010, hbar, hbar, 16'd0, 4'b0000);
    vecs[1]  = mkv(6'b010010, z,    vbar, 16'd1, 4'b0000);
    vecs[2]  = mkv(6'b010010, z,    hbar, 16'd2, 4'b0100);
    vecs[3]  = mkv(6'b000010, z,    hbar, 16'd2, 4'b0100);
    vecs[4]  = mkv(6'b001010, z,    hbar, 16'd2, 4'b0110);
    vecs[5]  = mkv(6'b001110, z,    vbar, 16'd3, 4'b0110);
    vecs[6]  = mkv(6'b011010, z,    vbar, 16'd3, 4'b0110);
    vecs[7]  = mkv(6'b010010, z,    vbar, 16'd3, 4'b0100);
    vecs[8]  = mkv(6'b001010, z,    vbar, 16'd3, 4'b0110);
    vecs[9]  = mkv(6'b101110, blk,  blk,  16'd0, 4'b0000);
    vecs[10] = mkv(6'b001011, z,    blk,  16'd0, 4'b0010);
    vecs[11] = mkv(6'b001111, z,    blk,  16'd1, 4'b1000);
    vecs[12] = mkv(6'b011111, z,    blk,  16'd1, 4'b1000);
    vecs[13] = mkv(6'b000010, z,    blk,  16'd1, 4'b1000);
    vecs[14] = mkv(6'b100010, z,    z,    16'd0, 4'b0001);
    vecs[15] = mkv(6'b001010, z,    z,    16'd0, 4'b0011);
    vecs[16] = mkv(6'b001110, z,    z,    16'd1, 4'b1011);
    vecs[17] = mkv(6'b001110, z,    z,    16'd2, 4'b1111);
    vecs[18] = mkv(6'b100000, cbar, cbar, 16'd0, 4'b0000);
    vecs[19] = mkv(6'b010000, z,    cdom, 16'd1, 4'b0000);
    vecs[20] = mkv(6'b100010, cbar, cbar, 16'd0, 4'b0000);
    vecs[21] = mkv(6'b010010, z,    cwrap, 16'd1, 4'b0000);

    // ---- reset ----
    reset = 1'b0; wrap = 1'b1; clear_ctl();
    i16 = '0; i8 = '0; i5s = '0; i5t = '0;
    repeat (2) cyc();
    chk("rst p16",  256'(p16), 256'(0));
    chk("rst g16",  256'(g16), 256'(0));
    chk("rst e16",  256'(e16), 256'(1));
    chk("rst s16",  256'(s16), 256'(0));
    chk("rst o16",  256'(o16), 256'(0));
    chk("rst r16",  256'(r16), 256'(0));
    chk("rst d16",  256'(d16), 256'(IDLE));
    chk("rst p8",   256'(p8),  256'(0));
    chk("rst e5s",  256'(e5s), 256'(1));
    chk("rst g5t",  256'(g5t), 256'(0));
    reset = 1'b1;

    // ---- vector table on the 16x16 board ----
    for (int i = 0; i < 22; i++) begin
      load = vecs[i].ld; step = vecs[i].st; run = vecs[i].rn;
      tick = vecs[i].tk; wrap = vecs[i].wr; auto_halt = vecs[i].ah;
      i16  = vecs[i].init;
      cyc();
      chk($sformatf("v%0d pixels", i),  256'(p16), 256'(vecs[i].exp_pix));
      chk($sformatf("v%0d gen", i),     256'(g16), 256'(vecs[i].exp_gen));
      chk($sformatf("v%0d stable", i),  256'(s16), 256'(vecs[i].exp_st));
      chk($sformatf("v%0d osc2", i),    256'(o16), 256'(vecs[i].exp_osc));
      chk($sformatf("v%0d running", i), 256'(r16), 256'(vecs[i].exp_run));
      chk($sformatf("v%0d extinct", i), 256'(e16), 256'(vecs[i].exp_ext));
    end
    clear_ctl();
    i16 = '0;

    // ---- glider on 8x8 torus: returns home after 32 generations ----
    glider = '0;
    glider[0][1] = 1'b1; glider[1][2] = 1'b1;
    glider[2][0] = 1'b1; glider[2][1] = 1'b1; glider[2][2] = 1'b1;
    i8 = glider; wrap = 1'b1; load = 1'b1;
    cyc();
    load = 1'b0; run = 1'b1; tick = 1'b1;
    repeat (33) cyc();   // first edge enters RUN, then 32 advances
    chk("torus pixels", 256'(p8), 256'(glider));
    chk("torus gen",    256'(g8), 256'(32));

    // ---- glider with dead border settles into a corner block ----
    corner_blk = '0;
    corner_blk[6][6] = 1'b1; corner_blk[6][7] = 1'b1;
    corner_blk[7][6] = 1'b1; corner_blk[7][7] = 1'b1;
    run = 1'b0; tick = 1'b0; wrap = 1'b0; load = 1'b1;
    cyc();
    load = 1'b0; run = 1'b1; tick = 1'b1;
    repeat (31) cyc();   // 30 advances; block forms at generation 23
    chk("border pixels",  256'(p8), 256'(corner_blk));
    chk("border stable",  256'(s8), 256'(1));
    chk("border gen",     256'(g8), 256'(30));
    chk("border running", 256'(r8), 256'(1));
    clear_ctl();
    i8 = '0;

    // ---- Seeds rule on 5x5: domino dies, four edge neighbours born ----
    i5s = '0;
    i5s[2][1] = 1'b1; i5s[2][2] = 1'b1;
    seeds_exp = '0;
    seeds_exp[1][1] = 1'b1; seeds_exp[1][2] = 1'b1;
    seeds_exp[3][1] = 1'b1; seeds_exp[3][2] = 1'b1;
    wrap = 1'b1; load = 1'b1;
    cyc();
    load = 1'b0; step = 1'b1;
    cyc();
    step = 1'b0;
    chk("seeds pixels", 256'(p5s), 256'(seeds_exp));
    chk("seeds gen",    256'(g5s), 256'(1));

    // ---- 3-bit counter saturation, then reset mid-run ----
    blink5 = '0;
    blink5[2][1] = 1'b1; blink5[2][2] = 1'b1; blink5[2][3] = 1'b1;
    i5t = blink5; load = 1'b1;
    cyc();
    load = 1'b0; run = 1'b1; tick = 1'b1;
    repeat (11) cyc();   // 10 advances
    chk("sat gen",     256'(g5t), 256'(7));
    chk("sat pixels",  256'(p5t), 256'(blink5));
    chk("sat osc2",    256'(o5t), 256'(1));
    chk("sat running", 256'(r5t), 256'(1));
    reset = 1'b0; load = 1'b1;   // reset wins over load and tick
    cyc();
    chk("mrst pixels",  256'(p5t), 256'(0));
    chk("mrst gen",     256'(g5t), 256'(0));
    chk("mrst stable",  256'(s5t), 256'(0));
    chk("mrst osc2",    256'(o5t), 256'(0));
    chk("mrst running", 256'(r5t), 256'(0));
    chk("mrst extinct", 256'(e5t), 256'(1));
    chk("mrst state",   256'(d5t), 256'(IDLE));
    reset = 1'b1;
    clear_ctl();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
